// File: rtl/bip_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bip_control_unit
//  Description : Multi-cycle control unit for the BIP accumulator datapath.
//                Sequences FETCH / DECODE / EXEC / WB for each 16-bit
//                instruction {opcode, operand}, drives the accumulator mux,
//                ALU operation and data-memory strobes, and exposes a sticky
//                halt flag plus a saturating cycle counter for debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module bip_control_unit #(
    parameter int PC_W  = 11,
    parameter int OPC_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Enable,
    input  logic [OPC_W+PC_W-1:0] Instr_in,
    output logic [PC_W-1:0]       Pc_addr,
    output logic [PC_W-1:0]       Operand,
    output logic [1:0]            SelA,
    output logic                  SelB,
    output logic                  Op,
    output logic                  WrAcc,
    output logic                  WrRam,
    output logic                  RdRam,
    output logic                  Halted,
    output logic [CNT_W-1:0]      Cycle_count
);

    localparam int c_INSTR_W = OPC_W + PC_W;

    // FSM encoding
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_WB     = 3'd3;
    localparam logic [2:0] c_ST_HALT   = 3'd4;

    // Opcodes
    localparam logic [OPC_W-1:0] c_OPC_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] c_OPC_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] c_OPC_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] c_OPC_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] c_OPC_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] c_OPC_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] c_OPC_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] c_OPC_SUBI = OPC_W'(7);

    // Accumulator input mux selections
    localparam logic [1:0] c_SEL_MEM = 2'b00;
    localparam logic [1:0] c_SEL_IMM = 2'b01;
    localparam logic [1:0] c_SEL_ALU = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       rd_ram;
        logic       wr_ram;
        logic       wr_acc;
    } ctrl_t;

    // Control word for one opcode; unknown opcodes decode as NOP (all zero)
    function automatic ctrl_t f_decode(input logic [OPC_W-1:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            c_OPC_STO: begin
                c.wr_ram = 1'b1;
            end
            c_OPC_LD: begin
                c.sel_a  = c_SEL_MEM;
                c.rd_ram = 1'b1;
                c.wr_acc = 1'b1;
            end
            c_OPC_LDI: begin
                c.sel_a  = c_SEL_IMM;
                c.wr_acc = 1'b1;
            end
            c_OPC_ADD: begin
                c.sel_a  = c_SEL_ALU;
                c.rd_ram = 1'b1;
                c.wr_acc = 1'b1;
            end
            c_OPC_ADDI: begin
                c.sel_a  = c_SEL_ALU;
                c.sel_b  = 1'b1;
                c.wr_acc = 1'b1;
            end
            c_OPC_SUB: begin
                c.sel_a  = c_SEL_ALU;
                c.op     = 1'b1;
                c.rd_ram = 1'b1;
                c.wr_acc = 1'b1;
            end
            c_OPC_SUBI: begin
                c.sel_a  = c_SEL_ALU;
                c.sel_b  = 1'b1;
                c.op     = 1'b1;
                c.wr_acc = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    logic [2:0]           r_state;
    logic [PC_W-1:0]      r_pc;
    logic [c_INSTR_W-1:0] r_ir;
    logic                 r_halted;
    logic                 r_rd_ram;
    logic                 r_wr_ram;
    logic                 r_wr_acc;
    logic [CNT_W-1:0]     r_cycle_count;

    logic [2:0]           w_state_nxt;
    logic [PC_W-1:0]      w_pc_nxt;
    logic [c_INSTR_W-1:0] w_ir_nxt;
    logic                 w_halted_nxt;
    logic                 w_rd_ram_nxt;
    logic                 w_wr_ram_nxt;
    logic                 w_wr_acc_nxt;
    logic [CNT_W-1:0]     w_cycle_count_nxt;

    logic [OPC_W-1:0]     w_instr_opc;
    logic [OPC_W-1:0]     w_ir_opc;
    logic [OPC_W-1:0]     w_dec_opc;
    ctrl_t                w_dec;
    logic                 w_active;

    assign w_instr_opc = Instr_in[c_INSTR_W-1 -: OPC_W];
    assign w_ir_opc    = r_ir[c_INSTR_W-1 -: OPC_W];

    // While decoding, the fresh word from program memory is the one that
    // matters (it sets up the EXEC strobes); afterwards the latched IR is.
    assign w_dec_opc = (r_state == c_ST_DECODE) ? w_instr_opc : w_ir_opc;
    assign w_dec     = f_decode(w_dec_opc);

    // Datapath controls are only meaningful while an instruction is in
    // EXEC or WB; everywhere else they sit at zero.
    assign w_active = (r_state == c_ST_EXEC) || (r_state == c_ST_WB);

    // Next-state, next-strobe and counter logic
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_ir_nxt          = r_ir;
        w_halted_nxt      = r_halted;
        w_rd_ram_nxt      = 1'b0;
        w_wr_ram_nxt      = 1'b0;
        w_wr_acc_nxt      = 1'b0;
        w_cycle_count_nxt = r_cycle_count;

        case (r_state)
            c_ST_FETCH: begin
                if (Enable) begin
                    w_state_nxt = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                w_ir_nxt = Instr_in;
                if (w_instr_opc == c_OPC_HLT) begin
                    w_state_nxt  = c_ST_HALT;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_state_nxt  = c_ST_EXEC;
                    w_rd_ram_nxt = w_dec.rd_ram;
                    w_wr_ram_nxt = w_dec.wr_ram;
                end
            end
            c_ST_EXEC: begin
                w_state_nxt  = c_ST_WB;
                w_wr_acc_nxt = w_dec.wr_acc;
            end
            c_ST_WB: begin
                w_pc_nxt    = r_pc + PC_W'(1);
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_HALT: begin
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = c_ST_FETCH;
            end
        endcase

        // Count every clock outside HALT, stalls included; stick at max.
        if ((r_state != c_ST_HALT) && (r_cycle_count != c_CNT_MAX)) begin
            w_cycle_count_nxt = r_cycle_count + CNT_W'(1);
        end
    end

    // State, PC, IR, strobes and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_FETCH;
            r_pc          <= '0;
            r_ir          <= '0;
            r_halted      <= 1'b0;
            r_rd_ram      <= 1'b0;
            r_wr_ram      <= 1'b0;
            r_wr_acc      <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_ir          <= w_ir_nxt;
            r_halted      <= w_halted_nxt;
            r_rd_ram      <= w_rd_ram_nxt;
            r_wr_ram      <= w_wr_ram_nxt;
            r_wr_acc      <= w_wr_acc_nxt;
            r_cycle_count <= w_cycle_count_nxt;
        end
    end

    assign Pc_addr     = r_pc;
    assign Operand     = w_active ? r_ir[PC_W-1:0] : '0;
    assign SelA        = w_active ? w_dec.sel_a : 2'b00;
    assign SelB        = w_active & w_dec.sel_b;
    assign Op          = w_active & w_dec.op;
    assign WrAcc       = r_wr_acc;
    assign WrRam       = r_wr_ram;
    assign RdRam       = r_rd_ram;
    assign Halted      = r_halted;
    assign Cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bip_control_unit
//  Description : Self-checking bench for bip_control_unit. A program-memory
//                model feeds instructions; an instruction-level reference
//                model predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_control_unit;

    localparam int PC_W    = 11;
    localparam int OPC_W   = 5;
    localparam int CNT_W   = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PC_MOD  = (1 << PC_W);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             Enable = 1'b0;
    logic [15:0]      Instr_in;
    logic [PC_W-1:0]  Pc_addr;
    logic [PC_W-1:0]  Operand;
    logic [1:0]       SelA;
    logic             SelB;
    logic             Op;
    logic             WrAcc;
    logic             WrRam;
    logic             RdRam;
    logic             Halted;
    logic [CNT_W-1:0] Cycle_count;

    logic [15:0] pmem [0:PC_MOD-1];

    int n_cmp = 0;
    int n_err = 0;
    int m_pc;
    int m_cnt;
    int cyc;
    int wrram_cyc;

    bip_control_unit #(
        .PC_W (PC_W),
        .OPC_W(OPC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Enable     (Enable),
        .Instr_in   (Instr_in),
        .Pc_addr    (Pc_addr),
        .Operand    (Operand),
        .SelA       (SelA),
        .SelB       (SelB),
        .Op         (Op),
        .WrAcc      (WrAcc),
        .WrRam      (WrRam),
        .RdRam      (RdRam),
        .Halted     (Halted),
        .Cycle_count(Cycle_count)
    );

    always #5 clk = ~clk;

    // Program memory with one-cycle read latency
    always @(posedge clk) Instr_in <= pmem[Pc_addr];

    function automatic logic [15:0] mk(input int opc, input int opnd);
        logic [4:0]  o;
        logic [10:0] d;
        o = opc[4:0];
        d = opnd[10:0];
        return {o, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Compare every output against the model's view of this cycle
    task automatic check_all(input string tag, input int opnd, input int sa, input bit sb,
                             input bit op, input bit rd, input bit wr, input bit wa, input bit hl);
        if (WrRam === 1'b1) wrram_cyc = cyc;
        chk({tag, ".pc"},      32'(Pc_addr),     32'(m_pc));
        chk({tag, ".operand"}, 32'(Operand),     32'(opnd));
        chk({tag, ".sela"},    32'(SelA),        32'(sa));
        chk({tag, ".selb"},    32'(SelB),        32'(sb));
        chk({tag, ".op"},      32'(Op),          32'(op));
        chk({tag, ".rdram"},   32'(RdRam),       32'(rd));
        chk({tag, ".wrram"},   32'(WrRam),       32'(wr));
        chk({tag, ".wracc"},   32'(WrAcc),       32'(wa));
        chk({tag, ".halted"},  32'(Halted),      32'(hl));
        chk({tag, ".cnt"},     32'(Cycle_count), 32'(m_cnt));
    endtask

    task automatic tick(input bit halted);
        @(negedge clk);
        cyc++;
        if (!halted && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        Enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_pc  = 0;
        m_cnt = 0;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    // Run one instruction from FETCH, with 'stall' Enable=0 cycles first.
    // Expected controls come straight from the instruction table.
    task automatic exec_instr(input logic [15:0] w, input int stall);
        int  opc, opnd, sa;
        bit  alu, sb, op, rd, wr, wa;
        opc  = int'(w[15:11]);
        opnd = int'(w[10:0]);
        alu  = (opc >= 4) && (opc <= 7);
        sb   = alu && (opc % 2 == 1);
        op   = alu && (opc >= 6);
        rd   = (opc == 2) || (opc == 4) || (opc == 6);
        wr   = (opc == 1);
        wa   = (opc >= 2) && (opc <= 7);
        sa   = alu ? 2 : ((opc == 3) ? 1 : 0);
        pmem[m_pc] = w;
        Enable = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check_all("stall", 0, 0, 0, 0, 0, 0, 0, 0);
            tick(1'b0);
        end
        Enable = 1'b1;
        check_all("fetch", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1'b0);
        Enable = 1'($urandom_range(0, 1));
        check_all("decode", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1'b0);
        if (opc == 0) begin
            check_all("halt", 0, 0, 0, 0, 0, 0, 0, 1);
            return;
        end
        Enable = 1'($urandom_range(0, 1));
        check_all("exec", opnd, sa, sb, op, rd, wr, 0, 0);
        tick(1'b0);
        check_all("wb", opnd, sa, sb, op, 0, 0, wa, 0);
        tick(1'b0);
        m_pc = (m_pc + 1) % PC_MOD;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < PC_MOD; i++) pmem[i] = mk(8, 0);
        wrram_cyc = 0;

        // LDI 5, ADDI 3, STO 2, HLT
        do_reset();
        exec_instr(mk(3, 5), 0);
        exec_instr(mk(5, 3), 0);
        exec_instr(mk(1, 2), 0);
        chk("t1_wrram_cycle", 32'(wrram_cyc), 32'd11);
        exec_instr(mk(0, 0), 0);
        chk("t1_halt_cnt", 32'(Cycle_count), 32'd14);
        chk("t1_halt_pc",  32'(Pc_addr),     32'd3);
        Enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            check_all("t1_sticky", 0, 0, 0, 0, 0, 0, 0, 1);
        end

        // SUBI with immediate 0x7FF
        do_reset();
        exec_instr(mk(7, 'h7FF), 0);

        // Ten stall cycles at FETCH, then a LD
        exec_instr(mk(2, 'h155), 10);

        // Unknown opcode 11111
        exec_instr(mk(31, 'h2AA), 0);
        chk("t6_pc", 32'(Pc_addr), 32'(m_pc));

        // Random instruction mix with random stalls
        for (int i = 0; i < 60; i++) begin
            exec_instr(mk($urandom_range(1, 31), $urandom_range(0, PC_MOD - 1)),
                       $urandom_range(0, 2));
        end

        // NOP stream up to PC=0x7FF, then one more NOP wraps to 0
        while (m_pc != PC_MOD - 1) begin
            exec_instr(mk($urandom_range(8, 31), $urandom_range(0, PC_MOD - 1)), 0);
        end
        exec_instr(mk(8, 0), 0);
        chk("t4_wrap", 32'(Pc_addr), 32'd0);

        // Reset taken as a STO heads into EXEC
        pmem[m_pc] = mk(1, 'h3C);
        Enable = 1'b1;
        check_all("t5_fetch", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1'b0);
        check_all("t5_decode", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        m_pc  = 0;
        m_cnt = 0;
        check_all("t5_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n  = 1'b1;
        Enable = 1'b0;
        cyc    = 1;
        tick(1'b0);
        check_all("t5_after", 0, 0, 0, 0, 0, 0, 0, 0);

        // Normal operation resumes after the abort
        exec_instr(mk(3, 'h400), 0);
        exec_instr(mk(6, 'h011), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
